// File: rtl/msg_reg_pkg.sv
// Shared types and constants for the message register block.
package msg_reg_pkg;

  localparam int unsigned DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT     = 2'b01,
    TRANSMIT = 2'b11
  } state_e;

endpackage

// File: rtl/msg_reg_if.sv
// Message stream bundle: byte input strobe plus transmitter handshake and status.
interface msg_reg_if;

  logic       ready;
  logic       transmit_ready;
  logic [7:0] data;
  logic       blue;
  logic       tx_ctrl;
  logic [7:0] tx_byte;

  modport master (
    output ready, transmit_ready, data,
    input  blue, tx_ctrl, tx_byte
  );

  modport slave (
    input  ready, transmit_ready, data,
    output blue, tx_ctrl, tx_byte
  );

endinterface

// File: rtl/msg_reg_buf.sv
// Message byte store: synchronous write port, combinational read port, cleared on reset.
module msg_buf
  import msg_reg_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/msg_reg.sv
// Collects message bytes while in WAIT, then hands them one at a time to the
// transmitter with at least one idle cycle between strobes.
module msg_reg
  import msg_reg_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       ready,
  input  logic       transmit_ready,
  input  logic [7:0] data,
  output logic       blue,
  output logic       tx_ctrl,
  output logic [7:0] tx_byte
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            tx_ctrl_q, tx_ctrl_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            blue_q, blue_d;

  logic            we;
  logic [AW-1:0]   waddr;
  logic [7:0]      rdata;
  logic            fire;
  logic            last;

  // A write is accepted in IDLE (always slot 0) or in WAIT while space remains.
  assign we    = ready && ((state_q == IDLE) || ((state_q == WAIT) && (count_q < FULL)));
  assign waddr = (state_q == IDLE) ? '0 : wr_ptr_q[AW-1:0];
  assign fire  = (state_q == TRANSMIT) && transmit_ready && !tx_ctrl_q;
  assign last  = (rd_ptr_q == (count_q - ONE));

  msg_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .nRst    (nRst),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (ready)          state_d = WAIT;
      WAIT:     if (transmit_ready) state_d = TRANSMIT;
      TRANSMIT: if (fire && last)   state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tx_ctrl_d = 1'b0;
    tx_byte_d = tx_byte_q;
    unique case (state_q)
      IDLE: begin
        if (ready) begin
          count_d  = ONE;
          wr_ptr_d = ONE;
        end
      end
      WAIT: begin
        // The count update lands on the same edge as the move to TRANSMIT,
        // so a byte arriving with transmit_ready is still sent.
        if (we) begin
          count_d  = count_q + ONE;
          wr_ptr_d = wr_ptr_q + ONE;
        end
        if (transmit_ready) rd_ptr_d = '0;
      end
      TRANSMIT: begin
        if (fire) begin
          tx_ctrl_d = 1'b1;
          tx_byte_d = rdata;
          if (last) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + ONE;
          end
        end
      end
      default: ;
    endcase
    blue_d = (state_d == WAIT);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tx_ctrl_q <= 1'b0;
      tx_byte_q <= '0;
      blue_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tx_ctrl_q <= tx_ctrl_d;
      tx_byte_q <= tx_byte_d;
      blue_q    <= blue_d;
    end
  end

  assign blue    = blue_q;
  assign tx_ctrl = tx_ctrl_q;
  assign tx_byte = tx_byte_q;

endmodule

// File: tb/tb_msg_reg.sv
// Scoreboard bench for msg_reg: message-level reference model, decoupled monitor.
module tb_msg_reg;

  localparam int unsigned DEPTH = 8;

  logic clk  = 1'b0;
  logic nRst = 1'b0;

  msg_reg_if bus ();

  msg_reg #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .nRst           (nRst),
    .ready          (bus.ready),
    .transmit_ready (bus.transmit_ready),
    .data           (bus.data),
    .blue           (bus.blue),
    .tx_ctrl        (bus.tx_ctrl),
    .tx_byte        (bus.tx_byte)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = no message, 1 = collecting, 2 = being sent.
  int         mode = 0;
  logic [7:0] msg  [$];
  logic [7:0] expq [$];
  logic       last_tr   = 1'b0;
  logic       prev_ctrl = 1'b0;
  logic [7:0] last_byte = 8'h00;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    msg.delete();
    expq.delete();
    mode      = 0;
    last_tr   = 1'b0;
    prev_ctrl = 1'b0;
    last_byte = 8'h00;
  endtask

  initial forever begin
    @(posedge clk);
    if (nRst) begin
      case (mode)
        0: if (bus.ready) begin
             msg.delete();
             msg.push_back(bus.data);
             mode = 1;
           end
        1: begin
             if (bus.ready && msg.size() < DEPTH) msg.push_back(bus.data);
             if (bus.transmit_ready) begin
               foreach (msg[i]) expq.push_back(msg[i]);
               msg.delete();
               mode = 2;
             end
           end
        default: ;
      endcase
      last_tr = bus.transmit_ready;
    end
  end

  initial forever begin
    logic [7:0] b;
    @(negedge clk);
    if (nRst) begin
      check("blue", 8'(bus.blue), 8'(mode == 1));
      if (bus.tx_ctrl) begin
        check("strobe_gap", 8'(prev_ctrl), 8'h00);
        check("strobe_needs_tr", 8'(last_tr), 8'h01);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got %h expected no strobe", bus.tx_byte);
        end else begin
          b = expq.pop_front();
          check("tx_byte", bus.tx_byte, b);
          last_byte = b;
          if (expq.size() == 0 && mode == 2) mode = 0;
        end
      end else begin
        check("tx_byte_hold", bus.tx_byte, last_byte);
      end
      prev_ctrl = bus.tx_ctrl;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blue"}, 8'(bus.blue), 8'h00);
    check({tag, "_tx_ctrl"}, 8'(bus.tx_ctrl), 8'h00);
    check({tag, "_tx_byte"}, bus.tx_byte, 8'h00);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    nRst               = 1'b0;
    bus.ready          = 1'b1;
    bus.data           = 8'd5;
    bus.transmit_ready = 1'b0;
    #1;
    clear_model();
    check_reset_outputs("reset_now");
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_held");
    nRst      = 1'b1;
    bus.ready = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(negedge clk);
    bus.ready = 1'b1;
    bus.data  = d;
    @(negedge clk);
    bus.ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (mode != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (mode != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d bytes still pending expected 0", tag, expq.size());
      clear_model();
    end
  endtask

  task automatic run_tx(input string tag);
    @(negedge clk);
    bus.transmit_ready = 1'b1;
    wait_idle(tag);
    bus.transmit_ready = 1'b0;
  endtask

  initial begin
    int n;
    bus.ready          = 1'b0;
    bus.transmit_ready = 1'b0;
    bus.data           = 8'h00;

    apply_reset();
    // Nothing stored: a transmit request while idle must produce no strobe.
    @(negedge clk);
    bus.transmit_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.transmit_ready = 1'b0;

    send_byte(8'd5);
    run_tx("single");

    send_byte(8'h48);
    send_byte(8'h41);
    send_byte(8'h4E);
    @(negedge clk);
    bus.transmit_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.ready = 1'b1;
    bus.data  = 8'h77;
    @(negedge clk);
    bus.ready = 1'b0;
    wait_idle("multi");
    bus.transmit_ready = 1'b0;

    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    run_tx("full");

    send_byte(8'h11);
    @(negedge clk);
    bus.ready          = 1'b1;
    bus.data           = 8'h22;
    bus.transmit_ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    wait_idle("simul");
    bus.transmit_ready = 1'b0;

    // Reset right after the first of three strobes.
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    @(negedge clk);
    bus.transmit_ready = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.tx_ctrl && n < 50);
    check("midreset_strobe_seen", 8'(bus.tx_ctrl), 8'h01);
    nRst = 1'b0;
    #1;
    clear_model();
    check_reset_outputs("midreset");
    bus.transmit_ready = 1'b0;
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    send_byte(8'hB1);
    send_byte(8'hB2);
    run_tx("after_reset");

    repeat (400) begin
      @(negedge clk);
      bus.ready          = ($urandom % 4) == 0;
      bus.data           = 8'($urandom);
      bus.transmit_ready = ($urandom % 5) == 0;
    end
    @(negedge clk);
    bus.ready = 1'b0;
    if (mode != 0) begin
      bus.transmit_ready = 1'b1;
      wait_idle("random_drain");
      bus.transmit_ready = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("leftover_expected", 8'(expq.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
